id_ex_pipe: RTL
===============

# id_ex_pipe

ID/EX pipeline register for the five-stage RV32 core. It captures the decoder's control bundle, the register-file operands, the immediate, the funct bits and the register addresses at the end of ID, and presents them to EX one cycle later. It also contains the load-use hazard detector, which drives the PC/IF-ID stall and inserts a bubble. It sits directly downstream of the control unit and the register file, and directly upstream of the ALU-control, forwarding and EX logic.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- hold_i  in  1  global pipeline freeze (memory stall); register keeps its contents
- flush_i  in  1  taken branch resolved in ID; the current ID instruction becomes a bubble
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  control bundle from the decoder
- ALUOp_i  in  2  ALU operation class from the decoder
- RS1data_i, RS2data_i  in  DATA_W  register-file read data
- Imm_i  in  DATA_W  sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW  register addresses of the ID instruction
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o  out  1 each  registered control
- ALUOp_o  out  2  registered ALUOp
- RS1data_o, RS2data_o, Imm_o  out  DATA_W  registered data
- funct_o  out  10  registered funct
- RS1addr_o, RS2addr_o, RDaddr_o  out  REG_AW  registered addresses (used by forwarding)
- valid_o  out  1  EX slot holds a real instruction
- Stall_o  out  1  load-use hazard detected (combinational)
- PCWrite_o  out  1  PC update enable = ~Stall_o & ~hold_i
- IFIDWrite_o  out  1  IF/ID update enable = ~Stall_o & ~hold_i

## Operation
- Load-use detection: `Stall_o = valid_o & MemRead_o & (RDaddr_o != 0) & (RDaddr_o == RS1addr_i | RDaddr_o == RS2addr_i)`.
  - RS2 is compared for every format. Spurious stalls on I-type instructions are accepted.
- Update priority on each clock edge, highest first:
  1. rst_i: every output register goes to 0, valid_o = 0.
  2. hold_i: all registers keep their values. This includes a bubble already held.
  3. flush_i or Stall_o: bubble. RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc and ALUOp are cleared, valid_o = 0. Data, funct and address fields load normally from the inputs.
  4. Otherwise: every field loads from its input, valid_o = 1.
- A bubble must never write the register file or memory. RegWrite_o = 0 and MemWrite_o = 0 whenever valid_o = 0.
- flush_i and Stall_o asserted together: a single bubble is inserted, and Stall_o is still asserted. flush_i does not mask PCWrite_o.
- Because the register takes a bubble, the stall self-clears the following cycle. The stall never lasts more than 1 cycle per load unless hold_i intervenes.

## Timing
- Latency is 1 cycle from the ID inputs to the registered outputs.
- Stall_o, PCWrite_o and IFIDWrite_o are combinational from the current register state and the ID address inputs. There is no registered path.
- Reset values: all registered outputs are 0, valid_o = 0. Stall_o is therefore 0 and PCWrite_o/IFIDWrite_o are 1 while hold_i = 0.
- Reset asserted mid-stall or mid-hold clears state on the next edge. Stall_o then drops within the same cycle that valid_o drops.
- hold_i during an active Stall_o keeps Stall_o high for every held cycle. The bubble is inserted on the first edge with hold_i = 0.

## Structure
- Shared package/defines file, common with the decoder: ALUOp encodings (R_OP, B_OP, OTHER_OP), opcode constants, the REG/MEM and REG/IMM select values, and the DATA_W/REG_AW defaults.
- One sub-module, load_use_detect, holds the combinational hazard compare and the enable generation. The rest is the register with its priority mux.

## Test plan
- Reset: rst_i = 1 for 2 cycles with arbitrary inputs -> all outputs 0, valid_o = 0, PCWrite_o = 1.
- Normal pass: add x3,x1,x2 inputs (RegWrite = 1, ALUOp = R_OP, RS1data = 5, RS2data = 7) -> identical values on the outputs one cycle later, valid_o = 1, Stall_o = 0.
- Load-use: lw x5 latched (MemRead_o = 1, RDaddr_o = 5), then ID presents RS1addr_i = 5 -> Stall_o = 1 and PCWrite_o = IFIDWrite_o = 0 that cycle. The next cycle shows a bubble (valid_o = 0, all control 0) and Stall_o = 0.
- x0 exemption: lw x0 latched, RS1addr_i = 0 -> Stall_o = 0 and normal load.
- Flush: flush_i = 1 with a store in ID (MemWrite_i = 1) -> MemWrite_o = 0, valid_o = 0 the next cycle.
- Hold over a stall: hold_i = 1 for 3 cycles during a load-use -> outputs frozen and Stall_o = 1 throughout. After hold_i drops, exactly one bubble is inserted, then the dependent instruction loads with valid_o = 1.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared decode definitions for the RV32 core: ALUOp classes, opcodes,
// mux select values, width defaults and the ID/EX control bundle.
package id_ex_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int FUNCT_W    = 10;

    // ALU operation class handed from the decoder to ALU-control
    localparam logic [1:0] OTHER_OP = 2'b00;  // address add for loads/stores, immediates
    localparam logic [1:0] B_OP     = 2'b01;  // branch compare
    localparam logic [1:0] R_OP     = 2'b10;  // register-register, decoded from funct

    // Major opcodes
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // Write-back select (MemtoReg)
    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // Second ALU operand select (ALUSrc)
    localparam logic SEL_RS2 = 1'b0;
    localparam logic SEL_IMM = 1'b1;

    // Control bundle carried through ID/EX
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // A killed slot carries no side effects: every control bit is dropped.
    function automatic ctrl_t bubble_ctrl(input ctrl_t c, input logic kill);
        return kill ? CTRL_NOP : c;
    endfunction

    // True when a destination register is architecturally writable (x0 is not).
    function automatic logic rd_is_live(input logic [REG_AW_DEF-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// Load-use hazard compare between the load sitting in EX and the operands
// of the instruction in ID, plus the PC and IF/ID write enables.
module id_ex_pipe_load_use_detect
    import id_ex_pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_vld,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              hold,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // Hazard compare: rs2 is checked for every format, so an I-type whose
    // immediate bits alias the load destination stalls one harmless cycle.
    always_comb begin
        rd_live    = (ex_rd_addr != '0);
        rs1_hit    = (ex_rd_addr == id_rs1_addr);
        rs2_hit    = (ex_rd_addr == id_rs2_addr);
        stall      = ex_vld & ex_mem_read & rd_live & (rs1_hit | rs2_hit);
        pc_write   = ~stall & ~hold;
        ifid_write = ~stall & ~hold;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with the load-use hazard detector. A stall or a
// flush turns the captured slot into a bubble; hold freezes everything.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [9:0]        funct_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [9:0]        funct_o,
    output logic [REG_AW-1:0] RS1addr_o,
    output logic [REG_AW-1:0] RS2addr_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic              valid_o,
    output logic              Stall_o,
    output logic              PCWrite_o,
    output logic              IFIDWrite_o
);

    ctrl_t             ctrl_p0;
    logic              kill_p0;
    logic              stall_p0;

    ctrl_t             ctrl_p1;
    logic [DATA_W-1:0] rs1_data_p1;
    logic [DATA_W-1:0] rs2_data_p1;
    logic [DATA_W-1:0] imm_p1;
    logic [9:0]        funct_p1;
    logic [REG_AW-1:0] rs1_addr_p1;
    logic [REG_AW-1:0] rs2_addr_p1;
    logic [REG_AW-1:0] rd_addr_p1;
    logic              vld_p1;

    // ---- ID stage (p0): decoder bundle and hazard decision ----
    always_comb begin
        ctrl_p0.reg_write  = RegWrite_i;
        ctrl_p0.mem_to_reg = MemtoReg_i;
        ctrl_p0.mem_read   = MemRead_i;
        ctrl_p0.mem_write  = MemWrite_i;
        ctrl_p0.alu_src    = ALUSrc_i;
        ctrl_p0.alu_op     = ALUOp_i;
        kill_p0            = flush_i | stall_p0;
    end

    id_ex_pipe_load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_vld      (vld_p1),
        .ex_mem_read (ctrl_p1.mem_read),
        .ex_rd_addr  (rd_addr_p1),
        .id_rs1_addr (RS1addr_i),
        .id_rs2_addr (RS2addr_i),
        .hold        (hold_i),
        .stall       (stall_p0),
        .pc_write    (PCWrite_o),
        .ifid_write  (IFIDWrite_o)
    );

    // ---- ID/EX boundary (p1): reset, then hold, then bubble, else load ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_p1     <= CTRL_NOP;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            funct_p1    <= '0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rd_addr_p1  <= '0;
            vld_p1      <= 1'b0;
        end else if (!hold_i) begin
            ctrl_p1     <= bubble_ctrl(ctrl_p0, kill_p0);
            rs1_data_p1 <= RS1data_i;
            rs2_data_p1 <= RS2data_i;
            imm_p1      <= Imm_i;
            funct_p1    <= funct_i;
            rs1_addr_p1 <= RS1addr_i;
            rs2_addr_p1 <= RS2addr_i;
            rd_addr_p1  <= RDaddr_i;
            vld_p1      <= ~kill_p0;
        end
    end

    // ---- EX stage view of the registered slot ----
    always_comb begin
        RegWrite_o = ctrl_p1.reg_write;
        MemtoReg_o = ctrl_p1.mem_to_reg;
        MemRead_o  = ctrl_p1.mem_read;
        MemWrite_o = ctrl_p1.mem_write;
        ALUSrc_o   = ctrl_p1.alu_src;
        ALUOp_o    = ctrl_p1.alu_op;
        RS1data_o  = rs1_data_p1;
        RS2data_o  = rs2_data_p1;
        Imm_o      = imm_p1;
        funct_o    = funct_p1;
        RS1addr_o  = rs1_addr_p1;
        RS2addr_o  = rs2_addr_p1;
        RDaddr_o   = rd_addr_p1;
        valid_o    = vld_p1;
        Stall_o    = stall_p0;
    end

endmodule
